sha256_unrolled_core: RTL
=========================

# sha256_unrolled_core

Parametrised SHA-256 compression core: computes `UNROLL` rounds per clock over one 512-bit block, with valid/ready handshakes on both sides. It optionally chains from its own previous digest, so multi-block messages run back-to-back without the caller feeding `hin`. It is the drop-in successor to the single-round core in the bitcoin_hash datapath. The nonce sweeper picks `UNROLL` to trade area for throughput.

## Interface
- `UNROLL`, default 1: rounds per cycle. Legal values are 1, 2, 4, 8; anything else is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: block request.
- `in_ready` out 1: core can accept a block.
- `message[15:0]` in 16x32: `message[0]` = W0 (first big-endian word).
- `hin[7:0]` in 8x32: input chaining value. `hin[0]` = H0. Ignored when `chain`=1.
- `chain` in 1: sampled at accept. When 1, use the internal digest register instead of `hin`.
- `out_valid` out 1: `hout` holds a finished digest.
- `out_ready` in 1: consumer takes the digest.
- `hout[7:0]` out 8x32: `hout[i]` = H_i', i.e. the final working variable plus the chaining value.

## Operation
- States: IDLE, COMPUTE, DONE.
- `in_ready` = (state==IDLE), combinational. No other output depends combinationally on an input.
- Accept happens when `in_valid` && `in_ready` at a rising edge, in IDLE. On that edge the core:
  - latches `message` into a 16-word schedule window;
  - latches the chaining value (`hin`, or the digest register if `chain`=1) into `hsave` and into a..h;
  - clears round counter `t` to 0;
  - moves to COMPUTE.
- COMPUTE, each cycle:
  - applies rounds t..t+UNROLL-1 combinationally in sequence;
  - computes UNROLL new schedule words (σ0/σ1 recurrence; later words may use earlier words from the same cycle) and shifts the window by UNROLL;
  - sets t += UNROLL.
  - Rounds 0–15 use the latched message words directly.
- Last COMPUTE cycle (t==64−UNROLL) registers the following, then moves to DONE:
  - `hout[i]` = var_i + `hsave[i]`;
  - digest register = the same values;
  - `out_valid`=1.
- DONE: hold `hout` and `out_valid` stable until `out_valid` && `out_ready`. Then deassert `out_valid` and move to IDLE.
- `in_valid` outside IDLE is ignored; no queuing.
- All additions are mod 2^32 with carries discarded. Rotates are true 32-bit rotates.
- The digest register persists across blocks. It is reloaded only at completion or reset.
- `chain`=1 on the first block after reset chains from the SHA-256 IV.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, so `in_ready`=1;
  - `out_valid`=0;
  - `hout` all 0;
  - digest register = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19;
  - t=0.
- Latency: accept at edge T gives `out_valid` high after edge T+64/UNROLL. That is 64 cycles for UNROLL=1 and 8 cycles for UNROLL=8.
- Throughput, with `out_ready` tied to 1: one block per 64/UNROLL+2 cycles (accept, compute, DONE, IDLE).
- Reset asserted mid-COMPUTE or in DONE: the block is abandoned, reset values apply immediately, and no `out_valid` pulse occurs.
- Back-pressure: if `out_ready`=0, DONE holds indefinitely and `in_ready` stays 0.
- `chain` and `hin` are sampled only on the accept edge. Changes afterwards have no effect.

## Test plan
- "abc" single padded block, `hin`=IV, `chain`=0, UNROLL=1 → after 64 cycles, `hout` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-message padded block (`message[0]`=80000000, rest 0), `chain`=1 straight after reset → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. This shows the digest register resets to IV.
- "abcdbcde…nopq" two-block message: block 1 with `hin`=IV, block 2 with `chain`=1 and `hin` driven to garbage → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Repeat the "abc" test at UNROLL=2, 4 and 8 → same digest, with `out_valid` exactly 32, 16 and 8 cycles after accept.
- Hold `out_ready`=0 for 20 cycles in DONE while pulsing `in_valid` → `hout` stable, `in_ready`=0, no second block accepted. Then `out_ready`=1 gives a one-cycle handshake, and `in_ready`=1 on the next cycle.
- Assert `reset_n` low at round 30 of a block → `out_valid` stays 0. After release, the "abc" block with `chain`=1 still produces the "abc" digest.

Source files
------------

// File: rtl/sha256_unrolled_core.sv
// sha256_unrolled_core
//   SHA-256 compression core that evaluates UNROLL rounds per clock over one
//   512-bit block. It can chain from its own previous digest, so multi-block
//   messages run back-to-back without the caller supplying hin.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   block request
//   in_ready   high in IDLE: a block can be accepted
//   message    16 x 32-bit words, message[0] = W0
//   hin        8 x 32-bit chaining value, hin[0] = H0 (ignored when chain=1)
//   chain      1: chain from the internal digest register instead of hin
//   out_valid  hout holds a finished digest
//   out_ready  consumer takes the digest
//   hout       8 x 32-bit digest, hout[i] = H_i'
module sha256_unrolled_core #(
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][31:0] message,
  input  logic [7:0][31:0]  hin,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0][31:0]  hout
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_unrolled_core: UNROLL must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [6:0] STEP_T = 7'(UNROLL);
  localparam logic [6:0] LAST_T = 7'(64 - UNROLL);

  // Concatenation lists H7 first so that index [i] holds H_i.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t           state_r;
  logic [6:0]       t_r;
  logic [15:0][31:0] w_r;        // w_r[0] is W_t for the current round
  logic [7:0][31:0]  hsave_r;
  logic [7:0][31:0]  var_r;      // var_r[0] = a ... var_r[7] = h
  logic [7:0][31:0]  digest_r;
  logic [7:0][31:0]  hout_r;
  logic             out_valid_r;

  logic [7:0][31:0]  var_next_s;
  logic [15:0][31:0] win_next_s;
  logic [7:0][31:0]  sum_s;
  logic [7:0][31:0]  chain_sel_s;

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = out_valid_r;
  assign hout        = hout_r;
  assign chain_sel_s = chain ? digest_r : hin;

  // UNROLL rounds and schedule steps chained within one cycle.
  always_comb begin
    logic [31:0] t1_v;
    logic [31:0] t2_v;
    logic [31:0] wnew_v;
    logic [5:0]  idx_v;
    t1_v       = 32'h0;
    t2_v       = 32'h0;
    wnew_v     = 32'h0;
    idx_v      = 6'd0;
    var_next_s = var_r;
    win_next_s = w_r;
    for (int j = 0; j < UNROLL; j++) begin
      idx_v  = t_r[5:0] + 6'(j);
      t1_v   = var_next_s[7] + big_sigma1(var_next_s[4])
             + ((var_next_s[4] & var_next_s[5]) ^ (~var_next_s[4] & var_next_s[6]))
             + K[idx_v] + win_next_s[0];
      t2_v   = big_sigma0(var_next_s[0])
             + ((var_next_s[0] & var_next_s[1]) ^ (var_next_s[0] & var_next_s[2])
                ^ (var_next_s[1] & var_next_s[2]));
      var_next_s = {var_next_s[6:4], var_next_s[3] + t1_v, var_next_s[2:0], t1_v + t2_v};
      // Window slides by one: the word just consumed drops off, W_{t+16} enters.
      wnew_v = small_sigma1(win_next_s[14]) + win_next_s[9]
             + small_sigma0(win_next_s[1]) + win_next_s[0];
      win_next_s = {wnew_v, win_next_s[15:1]};
    end
  end

  // Final feed-forward addition of the chaining value.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < 8; i++) begin
      sum_s[i] = var_next_s[i] + hsave_r[i];
    end
  end

  // Control FSM, working state, digest register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      t_r         <= 7'd0;
      w_r         <= '0;
      hsave_r     <= '0;
      var_r       <= '0;
      digest_r    <= IV;
      hout_r      <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            w_r     <= message;
            hsave_r <= chain_sel_s;
            var_r   <= chain_sel_s;
            t_r     <= 7'd0;
            state_r <= COMPUTE;
          end
        end
        COMPUTE: begin
          var_r <= var_next_s;
          w_r   <= win_next_s;
          t_r   <= t_r + STEP_T;
          if (t_r == LAST_T) begin
            hout_r      <= sum_s;
            digest_r    <= sum_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
